inverter_delay_meter: RTL and testbench

INVERTER_DELAY_METER -- requirements
Module: inverter_delay_meter

---
 rtl/inverter_delay_meter.sv | 126 ++++++++++++
 tb/tb_inverter_delay_meter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverter_delay_meter.sv
// Measures the propagation delay of an external inverter in clock cycles.
// Optional DELAY_SYNC_COMP_EN removes the two-cycle synchronizer latency from the result.
module inverter_delay_meter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t     state_q;
  logic [1:0] resp_sync_q, start_sync_q, sync_vld_q;
  logic       start_prev_q, start_armed_q;
  logic       edge_sel_q, stim_q, busy_q, done_q, timeout_q, settle_err_q;
  logic [3:0] settle_cnt_q;
  logic [7:0] cnt_q, result_q;

  logic       resp_s, start_s, start_accept;
  logic [7:0] meas_result_d;
  logic       unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};
  assign resp_s    = resp_sync_q[1];
  assign start_s   = start_sync_q[1];

  always_comb begin
    start_accept = start_armed_q & start_s & ~start_prev_q &
                   ((state_q == IDLE) | (state_q == DONE));
`ifdef DELAY_SYNC_COMP_EN
    meas_result_d = (cnt_q >= 8'd2) ? (cnt_q - 8'd2) : '0;
`else
    meas_result_d = cnt_q;
`endif
  end

  // Start edges count only once the synchronized level has been seen low
  // after reset, so a level held high through reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_sync_q   <= '0;
      start_sync_q  <= '0;
      sync_vld_q    <= '0;
      start_prev_q  <= 1'b0;
      start_armed_q <= 1'b0;
    end else begin
      resp_sync_q   <= {resp_sync_q[0], ui_in[0]};
      start_sync_q  <= {start_sync_q[0], ui_in[1]};
      sync_vld_q    <= {sync_vld_q[0], 1'b1};
      start_prev_q  <= start_s;
      start_armed_q <= start_armed_q | (sync_vld_q[1] & ~start_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      edge_sel_q   <= 1'b0;
      stim_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      settle_err_q <= 1'b0;
      settle_cnt_q <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
    end else if (start_accept) begin
      state_q      <= SETTLE;
      edge_sel_q   <= ui_in[2];
      stim_q       <= ui_in[2];
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      settle_err_q <= 1'b0;
      settle_cnt_q <= '0;
      result_q     <= '0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (settle_cnt_q == 4'd15) begin
            if (resp_s == ~edge_sel_q) begin
              state_q <= MEASURE;
              stim_q  <= ~edge_sel_q;
              cnt_q   <= '0;
            end else begin
              state_q      <= DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              settle_err_q <= 1'b1;
              result_q     <= '0;
            end
          end else begin
            settle_cnt_q <= settle_cnt_q + 4'd1;
          end
        end
        MEASURE: begin
          // Expected post-level response is ~(~edge_sel), i.e. edge_sel itself.
          if (resp_s == edge_sel_q) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= meas_result_d;
          end else if (cnt_q == 8'd255) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            result_q  <= 8'd255;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = {3'b000, settle_err_q, timeout_q, done_q, busy_q, stim_q};
  assign uio_out = result_q;
  assign uio_oe  = '1;

endmodule

// File: tb/tb_inverter_delay_meter.sv
// Self-checking bench: external inverter model with configurable delay or stuck response.
module tb_inverter_delay_meter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       es = 1'b0;
  logic       resp;
  logic [7:0] ui_in, uo_out, uio_out, uio_oe;
  logic [299:0] hist = '0;

  int dly  = 0;
  int mode = 0;          // 0 inverter with delay dly, 1 stuck at 0, 2 stuck at 1
  logic prev_stim = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ui_in = {5'b00000, es, start, resp};

  inverter_delay_meter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (1'b1),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (8'h00),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always @(posedge clk) hist <= {hist[298:0], uo_out[0]};

  always_comb begin
    resp = 1'b0;
    case (mode)
      0: resp = (dly == 0) ? ~uo_out[0] : ~hist[dly-1];
      1: resp = 1'b0;
      default: resp = 1'b1;
    endcase
  end

  // Reference outcome of one measurement derived from the behavioural rules.
  task automatic model(input int n, input int m, input logic e, input logic pstim,
                       output int r, output logic to, output logic se,
                       output int busy, output logic fstim);
    logic pre, post, settle_ok, can_match;
    int   c;
    pre  = e;
    post = ~e;
    if (m == 0)      settle_ok = (pre == pstim) || (n <= 13);
    else if (m == 1) settle_ok = (pre == 1'b1);
    else             settle_ok = (pre == 1'b0);
    if (m == 0)      begin can_match = 1'b1; c = n + 2; end
    else if (m == 1) begin can_match = (post == 1'b1); c = 0; end
    else             begin can_match = (post == 1'b0); c = 0; end
    if (!settle_ok) begin
      r = 0; to = 0; se = 1; busy = 16; fstim = pre;
    end else if (can_match && c <= 255) begin
`ifdef DELAY_SYNC_COMP_EN
      r = (c >= 2) ? c - 2 : 0;
`else
      r = c;
`endif
      to = 0; se = 0; busy = 16 + c + 1; fstim = post;
    end else begin
      r = 255; to = 1; se = 0; busy = 16 + 256; fstim = post;
    end
  endtask

  task automatic apply_reset(input int idle);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_stim = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic do_run(input string tag, input int n, input int m, input logic e,
                        input int restart_at);
    int r_exp, busy_exp, cnt, wait_c;
    logic to_exp, se_exp, stim_exp, saw_stim1;
    model(n, m, e, prev_stim, r_exp, to_exp, se_exp, busy_exp, stim_exp);
    @(negedge clk);
    dly = n; mode = m; es = e;
    start = 1'b1;
    wait_c = 0;
    while (!uo_out[1] && wait_c < 30) begin
      @(negedge clk);
      wait_c++;
    end
    start = 1'b0;
    checks++;
    if (!uo_out[1]) begin
      failures++;
      $display("FAIL %s busy_start got 0 exp 1", tag);
      return;
    end
    cnt = 0;
    saw_stim1 = 1'b0;
    while (uo_out[1] && cnt < 400) begin
      cnt++;
      if (uo_out[0]) saw_stim1 = 1'b1;
      if (restart_at != 0 && cnt == restart_at) start = 1'b1;
      if (restart_at != 0 && cnt == restart_at + 4) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (cnt != busy_exp) begin
      failures++;
      $display("FAIL %s busy_cycles got %0d exp %0d", tag, cnt, busy_exp);
    end
    checks++;
    if (uio_out !== r_exp[7:0]) begin
      failures++;
      $display("FAIL %s result got %0d exp %0d", tag, uio_out, r_exp);
    end
    checks++;
    if (uo_out[4:0] !== {se_exp, to_exp, 1'b1, 1'b0, stim_exp}) begin
      failures++;
      $display("FAIL %s flags got %b exp %b", tag, uo_out[4:0],
               {se_exp, to_exp, 1'b1, 1'b0, stim_exp});
    end
    checks++;
    if (uo_out[7:5] !== 3'b000 || uio_oe !== 8'hFF) begin
      failures++;
      $display("FAIL %s const got %b/%h exp 000/ff", tag, uo_out[7:5], uio_oe);
    end
    if (m == 1 && e == 1'b0) begin
      checks++;
      if (saw_stim1) begin
        failures++;
        $display("FAIL %s stim_toggled got 1 exp 0", tag);
      end
    end
    prev_stim = stim_exp;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hFF) begin
      failures++;
      $display("FAIL reset_state got %h/%h/%h exp 00/00/ff", uo_out, uio_out, uio_oe);
    end
    apply_reset(10);
    checks++;
    if (uo_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle got %h exp 00", uo_out);
    end
  endtask

  task automatic test_zero_delay();
    do_run("zero_delay", 0, 0, 1'b0, 0);
  endtask

  task automatic test_delay5();
    do_run("delay5_es1", 5, 0, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      do_run("random", $urandom_range(12, 0), 0, 1'($urandom_range(1, 0)), 0);
  endtask

  task automatic test_stuck_high();
    do_run("stuck_high", 0, 2, 1'b0, 0);
  endtask

  task automatic test_start_in_done();
    do_run("start_in_done", 3, 0, 1'b0, 0);
  endtask

  task automatic test_stuck_low();
    do_run("stuck_low", 0, 1, 1'b0, 0);
  endtask

  task automatic test_restart_in_measure();
    do_run("restart_measure", 12, 0, 1'b0, 18);
  endtask

  task automatic test_settle_boundary();
    apply_reset(300);
    do_run("settle_ok13", 13, 0, 1'b1, 0);
    apply_reset(300);
    do_run("settle_err14", 14, 0, 1'b1, 0);
  endtask

  task automatic test_count_boundary();
    apply_reset(300);
    do_run("match_at_255", 253, 0, 1'b0, 0);
    apply_reset(300);
    do_run("timeout_254", 254, 0, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    int cnt, wait_c;
    logic saw_busy;
    @(negedge clk);
    dly = 10; mode = 0; es = 1'b0;
    start = 1'b1;
    wait_c = 0;
    while (!uo_out[1] && wait_c < 30) begin
      @(negedge clk);
      wait_c++;
    end
    start = 1'b0;
    cnt = 1;
    while (cnt < 19) begin
      @(negedge clk);
      cnt++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hFF) begin
      failures++;
      $display("FAIL reset_mid got %h/%h/%h exp 00/00/ff", uo_out, uio_out, uio_oe);
    end
    start = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    prev_stim = 1'b0;
    saw_busy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (uo_out[1] || uo_out[2]) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy) begin
      failures++;
      $display("FAIL held_start got busy/done exp idle");
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    do_run("after_reset_mid", 10, 0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_zero_delay();
    test_delay5();
    test_random();
    test_stuck_high();
    test_start_in_done();
    test_stuck_low();
    test_restart_in_measure();
    test_settle_boundary();
    test_count_boundary();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
